// File: rtl/pc_pkg.sv
// Shared definitions for the Gumnut program-counter sequencer and decoder.
package pc_pkg;

  localparam int DEFAULT_PC_W   = 12;
  localparam int DEFAULT_DISP_W = 8;

  typedef enum logic [3:0] {
    OP_NEXT = 4'd0,
    OP_JMP  = 4'd1,
    OP_JSB  = 4'd2,
    OP_RET  = 4'd3,
    OP_BZ   = 4'd4,
    OP_BNZ  = 4'd5,
    OP_BC   = 4'd6,
    OP_BNC  = 4'd7,
    OP_RETI = 4'd8,
    OP_ENAI = 4'd9,
    OP_DISI = 4'd10
  } pc_op_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return stack for jsb/ret and interrupt entry.
// Push-when-full and pop-when-empty are ignored; the caller flags the error.
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  logic [IW-1:0] wr_idx, top_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_idx  = IW'(count_q);
  assign top_idx = IW'(count_q - CW'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  // Next entry count: a push and a pop are never requested together.
  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + CW'(1);
    else if (do_pop) count_d = count_q - CW'(1);
  end

  // Entry count is control state; clearing it discards the contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  // Stack storage is pure data and carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: next-PC selection, conditional
// branches, return stack for jsb/ret and a single maskable interrupt.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W        = DEFAULT_PC_W,
  parameter int              DISP_W      = DEFAULT_DISP_W,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] INT_VEC     = PC_W'(1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [3:0]        op_i,
  input  logic              carry_i,
  input  logic              zero_i,
  input  logic [DISP_W-1:0] disp_i,
  input  logic [PC_W-1:0]   addr_i,
  input  logic              int_req_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              int_en_o,
  output logic              int_ack_o,
  output logic              stack_full_o,
  output logic              stack_empty_o,
  output logic              stack_err_o
);

  // Two's-complement displacement widened to the PC width.
  function automatic logic [PC_W-1:0] sext_disp(input logic signed [DISP_W-1:0] d);
    logic signed [PC_W-1:0] ext;
    ext = PC_W'(d);
    return $unsigned(ext);
  endfunction

  logic [PC_W-1:0] pc_q, pc_d;
  logic            int_en_q, int_en_d;
  logic            int_ack_q, int_ack_d;
  logic            err_q, err_d;

  logic [PC_W-1:0] inc, btgt, op_next, stk_din, stk_top;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic            err_set, take_int, int_blocked;
  logic signed [DISP_W-1:0] disp_s;

  assign disp_s      = disp_i;
  assign inc         = pc_q + PC_W'(1);
  assign btgt        = pc_q + sext_disp(disp_s);
  assign int_blocked = (op_i == OP_JSB) || (op_i == OP_RET) || (op_i == OP_RETI);
  // int_en_q is the pre-update value, so ENAI cannot take an interrupt itself.
  assign take_int    = en_i & int_en_q & int_req_i & ~stk_full & ~int_blocked;

  // Next PC, stack request and flag updates for the current operation.
  always_comb begin
    op_next   = inc;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = inc;
    err_set   = 1'b0;
    int_en_d  = int_en_q;
    case (op_i)
      OP_JMP: op_next = addr_i;
      OP_JSB: begin
        op_next = addr_i;
        if (stk_full) err_set  = 1'b1;
        else          stk_push = 1'b1;
      end
      OP_RET, OP_RETI: begin
        if (stk_empty) err_set = 1'b1;
        else begin
          stk_pop = 1'b1;
          op_next = stk_top;
        end
        if (op_i == OP_RETI) int_en_d = 1'b1;
      end
      OP_BZ:   op_next = zero_i   ? btgt : inc;
      OP_BNZ:  op_next = !zero_i  ? btgt : inc;
      OP_BC:   op_next = carry_i  ? btgt : inc;
      OP_BNC:  op_next = !carry_i ? btgt : inc;
      OP_ENAI: int_en_d = 1'b1;
      OP_DISI: int_en_d = 1'b0;
      default: op_next = inc;
    endcase

    pc_d      = op_next;
    int_ack_d = 1'b0;
    if (take_int) begin
      stk_push  = 1'b1;
      stk_din   = op_next;
      pc_d      = INT_VEC;
      int_en_d  = 1'b0;
      int_ack_d = 1'b1;
    end

    err_d = err_q | err_set;

    if (!en_i) begin
      pc_d      = pc_q;
      int_en_d  = int_en_q;
      err_d     = err_q;
      int_ack_d = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
    end
  end

  // PC, interrupt enable, ack pulse and sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      int_en_q  <= 1'b0;
      int_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      int_en_q  <= int_en_d;
      int_ack_q <= int_ack_d;
      err_q     <= err_d;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (stk_din),
    .top    (stk_top),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  assign pc_o          = pc_q;
  assign int_en_o      = int_en_q;
  assign int_ack_o     = int_ack_q;
  assign stack_full_o  = stk_full;
  assign stack_empty_o = stk_empty;
  assign stack_err_o   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against
// a queue-based reference model of the sequencer.
module tb_pc_sequencer;

  localparam int PC_W   = 12;
  localparam int DISP_W = 8;
  localparam int DEPTH  = 8;
  localparam int IVEC   = 1;
  localparam int MASK   = 12'hFFF;

  logic              clk, rst_ni, en_i, carry_i, zero_i, int_req_i;
  logic [3:0]        op_i;
  logic [DISP_W-1:0] disp_i;
  logic [PC_W-1:0]   addr_i, pc_o;
  logic              int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ie, m_ack, m_err;

  pc_sequencer #(
    .PC_W(PC_W), .DISP_W(DISP_W), .STACK_DEPTH(DEPTH),
    .RESET_PC(12'h000), .INT_VEC(12'h001)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .op_i(op_i),
    .carry_i(carry_i), .zero_i(zero_i), .disp_i(disp_i), .addr_i(addr_i),
    .int_req_i(int_req_i), .pc_o(pc_o), .int_en_o(int_en_o),
    .int_ack_o(int_ack_o), .stack_full_o(stack_full_o),
    .stack_empty_o(stack_empty_o), .stack_err_o(stack_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_ie = 0; m_ack = 0; m_err = 0;
  endtask

  // One enabled/stalled cycle of the sequencer, from the operation rules.
  task automatic model_step(input bit en, input int op, input bit c, input bit z,
                            input int d, input int a, input bit req);
    int inc, btgt, nxt, dv;
    bit new_ie, was_full;
    if (!en) begin
      m_ack = 0;
      return;
    end
    dv = (d >= 128) ? d - 256 : d;
    inc = (m_pc + 1) & MASK;
    btgt = (m_pc + dv) & MASK;
    nxt = inc;
    new_ie = m_ie;
    was_full = (m_stk.size() == DEPTH);
    case (op)
      1: nxt = a;
      2: begin
        nxt = a;
        if (was_full) m_err = 1; else m_stk.push_back(inc);
      end
      3, 8: begin
        if (m_stk.size() == 0) m_err = 1; else nxt = m_stk.pop_back();
        if (op == 8) new_ie = 1;
      end
      4: nxt = z ? btgt : inc;
      5: nxt = !z ? btgt : inc;
      6: nxt = c ? btgt : inc;
      7: nxt = !c ? btgt : inc;
      9: new_ie = 1;
      10: new_ie = 0;
      default: nxt = inc;
    endcase
    if (m_ie && req && !was_full && !(op == 2 || op == 3 || op == 8)) begin
      m_stk.push_back(nxt);
      m_pc = IVEC; m_ie = 0; m_ack = 1;
    end else begin
      m_pc = nxt; m_ie = new_ie; m_ack = 0;
    end
  endtask

  // Drive inputs (already just past an edge), take one edge, sample 1ns after.
  task automatic cyc(input bit en, input int op, input bit c, input bit z,
                     input int d, input int a, input bit req);
    en_i = en; op_i = 4'(op); carry_i = c; zero_i = z;
    disp_i = 8'(d); addr_i = 12'(a); int_req_i = req;
    @(posedge clk);
    model_step(en, op, c, z, d, a, req);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    en_i = 1'b0; op_i = 4'd0; carry_i = 1'b0; zero_i = 1'b0;
    disp_i = '0; addr_i = '0; int_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc_o, int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o} !== {12'h000, 5'b00010}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ie=%b ack=%b full=%b empty=%b err=%b, want pc=000 ie=0 ack=0 full=0 empty=1 err=0",
               pc_o, int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (pc_o !== 12'(i)) begin
        errors++; $display("FAIL next_seq%0d: pc=%h want %h", i, pc_o, 12'(i));
      end
    end
    cyc(1, 1, 0, 0, 0, 12'hFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_o !== 12'h000) begin
      errors++; $display("FAIL next_wrap: pc=%h want 000", pc_o);
    end
  endtask

  task automatic test_branch();
    int opv[6]  = '{4, 4, 6, 5, 7, 7};
    int dv[6]   = '{8'hFE, 8'hFE, 8'h7F, 8'h80, 8'h05, 8'h05};
    bit zv[6]   = '{1, 0, 0, 0, 0, 0};
    bit cv[6]   = '{0, 0, 1, 0, 0, 1};
    int want[6] = '{12'h00E, 12'h011, 12'h08F, 12'hF90, 12'h015, 12'h011};
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 0, 0, 12'h010, 0);
      cyc(1, opv[i], cv[i], zv[i], dv[i], 0, 0);
      checks++;
      if (pc_o !== 12'(want[i])) begin
        errors++; $display("FAIL branch%0d: pc=%h want %h", i, pc_o, 12'(want[i]));
      end
    end
  endtask

  task automatic test_jsb_ret();
    logic [11:0] got[3];
    cyc(1, 1, 0, 0, 0, 12'h020, 0);
    cyc(1, 2, 0, 0, 0, 12'h100, 0); got[0] = pc_o;
    cyc(1, 0, 0, 0, 0, 0, 0);       got[1] = pc_o;
    cyc(1, 3, 0, 0, 0, 0, 0);       got[2] = pc_o;
    checks++;
    if ({got[0], got[1], got[2], stack_empty_o} !== {12'h100, 12'h101, 12'h021, 1'b1}) begin
      errors++;
      $display("FAIL jsb_ret: pcs=%h,%h,%h empty=%b want 100,101,021 empty=1", got[0], got[1], got[2], stack_empty_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cyc(1, 1, 0, 0, 0, 12'h300, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 2, 0, 0, 0, 12'h200 + 16 * i, 0);
      if (i == 7) begin
        checks++;
        if ({stack_full_o, stack_err_o} !== 2'b10) begin
          errors++; $display("FAIL full_after_8: full=%b err=%b want 1 0", stack_full_o, stack_err_o);
        end
      end
    end
    checks++;
    if ({pc_o, stack_full_o, stack_err_o} !== {12'h280, 2'b11}) begin
      errors++; $display("FAIL jsb_overflow: pc=%h full=%b err=%b want 280 1 1", pc_o, stack_full_o, stack_err_o);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1, 3, 0, 0, 0, 0, 0);
      checks++;
      if (pc_o !== 12'(m_pc) || stack_err_o !== 1'b1) begin
        errors++; $display("FAIL ret%0d: pc=%h err=%b want %h 1", i, pc_o, stack_err_o, 12'(m_pc));
      end
    end
    checks++;
    if ({pc_o, stack_empty_o} !== {12'h302, 1'b1}) begin
      errors++; $display("FAIL ret_underflow: pc=%h empty=%b want 302 1", pc_o, stack_empty_o);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    cyc(1, 1, 0, 0, 0, 12'h030, 0);
    cyc(1, 9, 0, 0, 0, 0, 1);
    checks++;
    if ({pc_o, int_en_o, int_ack_o} !== {12'h031, 2'b10}) begin
      errors++; $display("FAIL enai_pending: pc=%h ie=%b ack=%b want 031 1 0", pc_o, int_en_o, int_ack_o);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({pc_o, int_en_o, int_ack_o} !== {12'(IVEC), 2'b01}) begin
      errors++; $display("FAIL int_taken: pc=%h ie=%b ack=%b want 001 0 1", pc_o, int_en_o, int_ack_o);
    end
    cyc(1, 8, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_o, int_en_o, int_ack_o, stack_empty_o} !== {12'h032, 3'b101}) begin
      errors++; $display("FAIL reti: pc=%h ie=%b ack=%b empty=%b want 032 1 0 1", pc_o, int_en_o, int_ack_o, stack_empty_o);
    end
  endtask

  task automatic test_defer();
    cyc(1, 1, 0, 0, 0, 12'h050, 0);
    cyc(1, 2, 0, 0, 0, 12'h100, 1);
    checks++;
    if ({pc_o, int_ack_o} !== {12'h100, 1'b0}) begin
      errors++; $display("FAIL defer_jsb: pc=%h ack=%b want 100 0", pc_o, int_ack_o);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({pc_o, int_ack_o, int_en_o} !== {12'(IVEC), 2'b10}) begin
      errors++; $display("FAIL defer_take: pc=%h ack=%b ie=%b want 001 1 0", pc_o, int_ack_o, int_en_o);
    end
    cyc(1, 8, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_o, stack_empty_o} !== {12'h051, 1'b1}) begin
      errors++; $display("FAIL defer_return: pc=%h empty=%b want 051 1", pc_o, stack_empty_o);
    end
  endtask

  task automatic test_stall();
    logic [11:0] pc_save;
    cyc(1, 2, 0, 0, 0, 12'h400, 0);
    cyc(1, 2, 0, 0, 0, 12'h500, 0);
    pc_save = pc_o;
    for (int i = 0; i < 5; i++) begin
      cyc(0, $urandom_range(0, 15), 1, 1, $urandom_range(0, 255), $urandom_range(0, MASK), 1);
      checks++;
      if ({pc_o, int_ack_o, stack_empty_o, int_en_o} !== {pc_save, 3'b001}) begin
        errors++; $display("FAIL stall%0d: pc=%h ack=%b empty=%b ie=%b want %h 0 0 1", i, pc_o, int_ack_o, stack_empty_o, int_en_o, pc_save);
      end
    end
    cyc(1, 3, 0, 0, 0, 0, 0);
    checks++;
    if (pc_o !== 12'h401) begin
      errors++; $display("FAIL stall_stack_kept: pc=%h want 401", pc_o);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 0, 0, 0, 12'h040, 0);
    cyc(1, 2, 0, 0, 0, 12'h100, 0);
    cyc(1, 2, 0, 0, 0, 12'h200, 0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pc_o, int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o} !== {12'h000, 5'b00010}) begin
      errors++;
      $display("FAIL reset_mid: pc=%h ie=%b ack=%b full=%b empty=%b err=%b want 000 0 0 0 1 0",
               pc_o, int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cyc(1, 3, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_o, stack_err_o} !== {12'h001, 1'b1}) begin
      errors++; $display("FAIL reset_discards_stack: pc=%h err=%b want 001 1", pc_o, stack_err_o);
    end
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, MASK),
          $urandom_range(0, 2) == 0);
      got = {pc_o, int_en_o, int_ack_o, stack_full_o, stack_empty_o, stack_err_o};
      exp = {12'(m_pc), m_ie, m_ack, m_stk.size() == DEPTH, m_stk.size() == 0, m_err};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random%0d: {pc,ie,ack,full,empty,err}=%h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_jsb_ret();
    test_overflow();
    test_interrupt();
    test_defer();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
